// File: rtl/axi_mst_initiator.sv
// AXI3-style traffic master: turns simple commands into AW/W or AR bursts carrying an
// address-derived data pattern, and checks B/R responses against issue order.
module axi_mst_initiator #(
  parameter int unsigned AXI_ADDR_W   = 32,
  parameter int unsigned AXI_ID_W     = 4,
  parameter int unsigned AXI_DATA_W   = 32,
  parameter int unsigned MST_OSTD_NUM = 4
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [AXI_ADDR_W-1:0]           cmd_addr,
  input  logic [3:0]                      cmd_len,
  input  logic [AXI_ID_W-1:0]             cmd_id,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [AXI_ADDR_W-1:0]           awaddr,
  output logic [3:0]                      awlen,
  output logic [2:0]                      awsize,
  output logic [1:0]                      awburst,
  output logic [AXI_ID_W-1:0]             awid,
  output logic [1:0]                      awlock,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [AXI_ID_W-1:0]             wid,
  output logic [AXI_DATA_W-1:0]           wdata,
  output logic [AXI_DATA_W/8-1:0]         wstrb,
  output logic                            wlast,
  input  logic                            bvalid,
  output logic                            bready,
  input  logic [AXI_ID_W-1:0]             bid,
  input  logic [1:0]                      bresp,
  output logic                            arvalid,
  input  logic                            arready,
  output logic [AXI_ADDR_W-1:0]           araddr,
  output logic [3:0]                      arlen,
  output logic [2:0]                      arsize,
  output logic [1:0]                      arburst,
  output logic [AXI_ID_W-1:0]             arid,
  output logic [1:0]                      arlock,
  input  logic                            rvalid,
  output logic                            rready,
  input  logic [AXI_ID_W-1:0]             rid,
  input  logic [AXI_DATA_W-1:0]           rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rlast,
  output logic [$clog2(MST_OSTD_NUM):0]   wr_ostd_cnt,
  output logic [$clog2(MST_OSTD_NUM):0]   rd_ostd_cnt,
  output logic [7:0]                      err_cnt,
  output logic                            idle
);

  localparam int unsigned STRB_W = AXI_DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(MST_OSTD_NUM);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [2:0]       AXSIZE   = 3'($clog2(STRB_W));
  localparam logic [CNT_W-1:0] OSTD_MAX = CNT_W'(MST_OSTD_NUM);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);

  typedef enum logic {W_IDLE, W_BURST} w_state_t;

  w_state_t w_state;

  // W FIFO {len,id,addr}, B-expect FIFO {id}, R-expect FIFO {len,id}
  logic [3:0]            wf_len  [MST_OSTD_NUM];
  logic [AXI_ID_W-1:0]   wf_id   [MST_OSTD_NUM];
  logic [AXI_ADDR_W-1:0] wf_addr [MST_OSTD_NUM];
  logic [AXI_ID_W-1:0]   bf_id   [MST_OSTD_NUM];
  logic [3:0]            rf_len  [MST_OSTD_NUM];
  logic [AXI_ID_W-1:0]   rf_id   [MST_OSTD_NUM];
  logic [PTR_W:0]        wf_wr, wf_rd, bf_wr, bf_rd, rf_wr, rf_rd;

  logic [3:0]            w_beat, w_len, r_beat;
  logic [AXI_ADDR_W-1:0] w_cur, w_nxt;
  logic [CNT_W-1:0]      wr_pend, rd_pend;
  logic [8:0]            err_sum;

  logic cmd_acc, aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic wf_empty, wf_full, bf_empty, rf_empty;
  logic w_load, b_err, b_pop, r_last_beat, r_close, r_err, r_pop;
  logic unused_rdata;

  assign aw_hs = awvalid & awready;
  assign ar_hs = arvalid & arready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign r_hs  = rvalid & rready;

  assign wf_empty = (wf_wr == wf_rd);
  assign wf_full  = (wf_wr[PTR_W] != wf_rd[PTR_W]) && (wf_wr[PTR_W-1:0] == wf_rd[PTR_W-1:0]);
  assign bf_empty = (bf_wr == bf_rd);
  assign rf_empty = (rf_wr == rf_rd);

  // A held address beat will still add one outstanding burst when it handshakes
  assign wr_pend   = wr_ostd_cnt + CNT_W'(awvalid);
  assign rd_pend   = rd_ostd_cnt + CNT_W'(arvalid);
  assign cmd_ready = cmd_write ? ((!awvalid || awready) && (wr_pend < OSTD_MAX) && !wf_full)
                               : ((!arvalid || arready) && (rd_pend < OSTD_MAX));
  assign cmd_acc   = cmd_valid & cmd_ready;

  assign w_load = !wf_empty && ((w_state == W_IDLE) || (w_hs && wlast));
  assign w_nxt  = w_cur + AXI_ADDR_W'(STRB_W);

  assign b_err = b_hs && (bf_empty || (bid != bf_id[bf_rd[PTR_W-1:0]]) || (bresp != 2'b00));
  assign b_pop = b_hs && !bf_empty;

  assign r_last_beat = (r_beat == rf_len[rf_rd[PTR_W-1:0]]);
  assign r_close     = rlast || r_last_beat;
  assign r_err       = r_hs && (rf_empty || (rid != rf_id[rf_rd[PTR_W-1:0]]) ||
                                (rresp != 2'b00) || (rlast != r_last_beat));
  assign r_pop       = r_hs && !rf_empty && r_close;

  assign err_sum = {1'b0, err_cnt} + 9'(b_err) + 9'(r_err);

  assign awlock = 2'b00;
  assign arlock = 2'b00;
  assign idle   = !awvalid && !arvalid && (w_state == W_IDLE) && wf_empty &&
                  (wr_ostd_cnt == '0) && (rd_ostd_cnt == '0);

  // Read data carries no checked pattern; only its framing is checked
  assign unused_rdata = ^rdata;

  // Expectation storage, written at the address handshakes
  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      wf_len[wf_wr[PTR_W-1:0]]  <= awlen;
      wf_id[wf_wr[PTR_W-1:0]]   <= awid;
      wf_addr[wf_wr[PTR_W-1:0]] <= awaddr;
      bf_id[bf_wr[PTR_W-1:0]]   <= awid;
    end
    if (ar_hs) begin
      rf_len[rf_wr[PTR_W-1:0]] <= arlen;
      rf_id[rf_wr[PTR_W-1:0]]  <= arid;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awvalid     <= 1'b0;
      awaddr      <= '0;
      awlen       <= '0;
      awsize      <= '0;
      awburst     <= '0;
      awid        <= '0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      arlen       <= '0;
      arsize      <= '0;
      arburst     <= '0;
      arid        <= '0;
      w_state     <= W_IDLE;
      wvalid      <= 1'b0;
      wid         <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      wlast       <= 1'b0;
      w_beat      <= '0;
      w_len       <= '0;
      w_cur       <= '0;
      bready      <= 1'b0;
      rready      <= 1'b0;
      r_beat      <= '0;
      wf_wr       <= '0;
      wf_rd       <= '0;
      bf_wr       <= '0;
      bf_rd       <= '0;
      rf_wr       <= '0;
      rf_rd       <= '0;
      wr_ostd_cnt <= '0;
      rd_ostd_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      bready <= 1'b1;
      rready <= 1'b1;

      if (cmd_acc && cmd_write) begin
        awvalid <= 1'b1;
        awaddr  <= cmd_addr;
        awlen   <= cmd_len;
        awid    <= cmd_id;
        awsize  <= AXSIZE;
        awburst <= 2'b01;
      end else if (aw_hs) begin
        awvalid <= 1'b0;
      end

      if (cmd_acc && !cmd_write) begin
        arvalid <= 1'b1;
        araddr  <= cmd_addr;
        arlen   <= cmd_len;
        arid    <= cmd_id;
        arsize  <= AXSIZE;
        arburst <= 2'b01;
      end else if (ar_hs) begin
        arvalid <= 1'b0;
      end

      if (aw_hs) begin
        wf_wr <= wf_wr + PTR_ONE;
        bf_wr <= bf_wr + PTR_ONE;
      end
      if (ar_hs) rf_wr <= rf_wr + PTR_ONE;

      // W engine: a waiting burst is chained straight onto the wlast handshake
      if (w_load) begin
        w_state <= W_BURST;
        wvalid  <= 1'b1;
        wid     <= wf_id[wf_rd[PTR_W-1:0]];
        w_len   <= wf_len[wf_rd[PTR_W-1:0]];
        w_beat  <= '0;
        w_cur   <= wf_addr[wf_rd[PTR_W-1:0]];
        wdata   <= AXI_DATA_W'(wf_addr[wf_rd[PTR_W-1:0]]);
        wstrb   <= '1;
        wlast   <= (wf_len[wf_rd[PTR_W-1:0]] == 4'd0);
        wf_rd   <= wf_rd + PTR_ONE;
      end else if (w_hs) begin
        if (wlast) begin
          w_state <= W_IDLE;
          wvalid  <= 1'b0;
          wlast   <= 1'b0;
        end else begin
          w_beat <= w_beat + 4'd1;
          w_cur  <= w_nxt;
          wdata  <= AXI_DATA_W'(w_nxt);
          wlast  <= ((w_beat + 4'd1) == w_len);
        end
      end

      if (b_pop) bf_rd <= bf_rd + PTR_ONE;

      if (r_hs && !rf_empty) begin
        if (r_close) begin
          rf_rd  <= rf_rd + PTR_ONE;
          r_beat <= '0;
        end else begin
          r_beat <= r_beat + 4'd1;
        end
      end

      case ({aw_hs, b_pop})
        2'b10:   wr_ostd_cnt <= wr_ostd_cnt + CNT_ONE;
        2'b01:   wr_ostd_cnt <= wr_ostd_cnt - CNT_ONE;
        default: wr_ostd_cnt <= wr_ostd_cnt;
      endcase

      case ({ar_hs, r_pop})
        2'b10:   rd_ostd_cnt <= rd_ostd_cnt + CNT_ONE;
        2'b01:   rd_ostd_cnt <= rd_ostd_cnt - CNT_ONE;
        default: rd_ostd_cnt <= rd_ostd_cnt;
      endcase

      err_cnt <= (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_axi_mst_initiator.sv
// Directed bench for axi_mst_initiator: write/read bursts, outstanding limits,
// response error counting, stall stability and asynchronous reset mid-burst.
module tb_axi_mst_initiator;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len, cmd_id;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen, awid;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic        wvalid, wready, wlast;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arlen, arid;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [2:0]  wr_ostd_cnt, rd_ostd_cnt;
  logic [7:0]  err_cnt;
  logic        idle;

  int tests = 0;
  int fails = 0;
  int bursts_done = 0;
  logic [3:0] lens [8] = '{4'd0, 4'd15, 4'd3, 4'd7, 4'd1, 4'd12, 4'd5, 4'd9};

  always #5 aclk = ~aclk;

  axi_mst_initiator dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid), .awlock(awlock),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid), .arlock(arlock),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .wr_ostd_cnt(wr_ostd_cnt), .rd_ostd_cnt(rd_ostd_cnt), .err_cnt(err_cnt), .idle(idle)
  );

  task automatic clear_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    areset = 1'b1;
    clear_inputs();
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // Presents a command from a negedge and returns at the negedge after acceptance
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [3:0] id);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    for (int i = 0; i < 400; i++) begin
      #2;
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL cmd_accept_timeout addr=%0h cmd_ready=%0b required=1", addr, cmd_ready);
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    bvalid = 1'b1; bid = id; bresp = resp;
    @(negedge aclk);
    bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [3:0] id, input logic [1:0] resp, input logic last);
    rvalid = 1'b1; rid = id; rdata = 32'hdead_0000 | 32'(id); rresp = resp; rlast = last;
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge aclk);
    #1;
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid got=%0b exp=0", awvalid); end
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid got=%0b exp=0", arvalid); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid got=%0b exp=0", wvalid); end
    tests++; if (bready !== 1'b0 || rready !== 1'b0) begin fails++; $display("FAIL reset_readies got=%0b%0b exp=00", bready, rready); end
    tests++; if (wr_ostd_cnt !== 3'd0 || rd_ostd_cnt !== 3'd0) begin fails++; $display("FAIL reset_ostd got=%0d/%0d exp=0/0", wr_ostd_cnt, rd_ostd_cnt); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got=%0b exp=1", idle); end
    tests++; if (awaddr !== 32'd0 || wdata !== 32'd0 || wstrb !== 4'd0) begin fails++; $display("FAIL reset_payload awaddr=%0h wdata=%0h wstrb=%0h exp=0", awaddr, wdata, wstrb); end
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    #1;
    tests++; if (bready !== 1'b1 || rready !== 1'b1) begin fails++; $display("FAIL post_reset_readies got=%0b%0b exp=11", bready, rready); end
  endtask

  task automatic test_write_basic();
    int beats;
    apply_reset();
    awready = 1'b1; wready = 1'b1;
    send_cmd(1'b1, 32'h100, 4'd3, 4'd5);
    #1;
    tests++; if (awvalid !== 1'b1) begin fails++; $display("FAIL wr_awvalid got=%0b exp=1", awvalid); end
    tests++; if (awaddr !== 32'h100 || awlen !== 4'd3 || awid !== 4'd5) begin fails++; $display("FAIL wr_aw_payload got=%0h/%0d/%0d exp=100/3/5", awaddr, awlen, awid); end
    tests++; if (awsize !== 3'd2 || awburst !== 2'b01 || awlock !== 2'b00) begin fails++; $display("FAIL wr_aw_fixed got=%0d/%0d/%0d exp=2/1/0", awsize, awburst, awlock); end
    beats = 0;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      #1;
      if (wvalid === 1'b1) begin
        if (beats == 0) begin
          tests++; if (wr_ostd_cnt !== 3'd1) begin fails++; $display("FAIL wr_ostd_one got=%0d exp=1", wr_ostd_cnt); end
        end
        tests++; if (wdata !== 32'h100 + 32'(beats) * 32'd4) begin fails++; $display("FAIL wr_wdata beat=%0d got=%0h exp=%0h", beats, wdata, 32'h100 + 32'(beats) * 32'd4); end
        tests++; if (wlast !== (beats == 3) || wid !== 4'd5 || wstrb !== 4'hf) begin fails++; $display("FAIL wr_wctl beat=%0d wlast=%0b wid=%0d wstrb=%0h exp=%0b/5/f", beats, wlast, wid, wstrb, beats == 3); end
        beats++;
      end
      @(negedge aclk);
    end
    tests++; if (beats != 4) begin fails++; $display("FAIL wr_beat_count got=%0d exp=4", beats); end
    #1;
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL wr_wvalid_end got=%0b exp=0", wvalid); end
    send_b(4'd5, 2'b00);
    #1;
    tests++; if (wr_ostd_cnt !== 3'd0 || err_cnt !== 8'd0 || idle !== 1'b1) begin fails++; $display("FAIL wr_done ostd=%0d err=%0d idle=%0b exp=0/0/1", wr_ostd_cnt, err_cnt, idle); end
  endtask

  task automatic test_read_ostd();
    apply_reset();
    arready = 1'b1;
    send_cmd(1'b0, 32'h210, 4'd1, 4'd1);
    #1;
    tests++; if (arvalid !== 1'b1 || araddr !== 32'h210 || arlen !== 4'd1 || arid !== 4'd1 || arsize !== 3'd2 || arburst !== 2'b01) begin
      fails++; $display("FAIL rd_ar_payload v=%0b a=%0h l=%0d id=%0d sz=%0d b=%0d exp=1/210/1/1/2/1", arvalid, araddr, arlen, arid, arsize, arburst); end
    for (int i = 2; i <= 4; i++) send_cmd(1'b0, 32'h200 + 32'(i) * 32'h10, 4'd1, 4'(i));
    repeat (2) @(negedge aclk);
    #1;
    tests++; if (rd_ostd_cnt !== 3'd4) begin fails++; $display("FAIL rd_ostd_full got=%0d exp=4", rd_ostd_cnt); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300; cmd_len = 4'd0; cmd_id = 4'd9;
    #1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rd_cmd_ready_full got=%0b exp=0", cmd_ready); end
    cmd_valid = 1'b0;
    @(negedge aclk);
    for (int i = 1; i <= 2; i++) begin
      send_r(4'(i), 2'b00, 1'b0);
      send_r(4'(i), 2'b00, 1'b1);
    end
    #1;
    tests++; if (rd_ostd_cnt !== 3'd2 || idle !== 1'b0) begin fails++; $display("FAIL rd_ostd_half got=%0d idle=%0b exp=2/0", rd_ostd_cnt, idle); end
    @(negedge aclk);
    for (int i = 3; i <= 4; i++) begin
      send_r(4'(i), 2'b00, 1'b0);
      send_r(4'(i), 2'b00, 1'b1);
    end
    #1;
    tests++; if (rd_ostd_cnt !== 3'd0 || err_cnt !== 8'd0 || idle !== 1'b1) begin fails++; $display("FAIL rd_drained ostd=%0d err=%0d idle=%0b exp=0/0/1", rd_ostd_cnt, err_cnt, idle); end
  endtask

  task automatic test_rlast_early();
    apply_reset();
    arready = 1'b1;
    send_cmd(1'b0, 32'h400, 4'd2, 4'd3);
    repeat (3) @(negedge aclk);
    send_r(4'd3, 2'b00, 1'b0);
    send_r(4'd3, 2'b00, 1'b1);
    #1;
    tests++; if (err_cnt !== 8'd1 || rd_ostd_cnt !== 3'd0) begin fails++; $display("FAIL rlast_early err=%0d ostd=%0d exp=1/0", err_cnt, rd_ostd_cnt); end
    @(negedge aclk);
    send_cmd(1'b0, 32'h500, 4'd0, 4'd6);
    repeat (3) @(negedge aclk);
    send_r(4'd6, 2'b00, 1'b1);
    #1;
    tests++; if (err_cnt !== 8'd1 || rd_ostd_cnt !== 3'd0) begin fails++; $display("FAIL rlast_followup err=%0d ostd=%0d exp=1/0", err_cnt, rd_ostd_cnt); end
  endtask

  task automatic test_random_stall();
    apply_reset();
    bursts_done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_cmd(1'b1, 32'h1000 + 32'(i) * 32'h100, lens[i], 4'(i));
      end
      begin
        int bi, bk, total;
        logic aw_hold, w_hold, p_wlast;
        logic [31:0] p_awaddr, p_wdata, exp_d;
        logic [3:0] p_awlen, p_wid;
        bi = 0; bk = 0; total = 0; aw_hold = 1'b0; w_hold = 1'b0;
        p_wlast = 1'b0; p_awaddr = '0; p_wdata = '0; p_awlen = '0; p_wid = '0;
        for (int c = 0; c < 4000 && total < 60; c++) begin
          @(negedge aclk);
          #1;
          if (aw_hold) begin
            tests++; if (awvalid !== 1'b1 || awaddr !== p_awaddr || awlen !== p_awlen) begin fails++; $display("FAIL stall_aw_stable got=%0b/%0h/%0d exp=1/%0h/%0d", awvalid, awaddr, awlen, p_awaddr, p_awlen); end
          end
          if (w_hold) begin
            tests++; if (wvalid !== 1'b1 || wdata !== p_wdata || wlast !== p_wlast || wid !== p_wid) begin fails++; $display("FAIL stall_w_stable got=%0b/%0h/%0b/%0d exp=1/%0h/%0b/%0d", wvalid, wdata, wlast, wid, p_wdata, p_wlast, p_wid); end
          end
          awready = 1'($urandom_range(0, 1));
          wready  = 1'($urandom_range(0, 1));
          if (wvalid === 1'b1 && wready && bi < 8) begin
            exp_d = 32'h1000 + 32'(bi) * 32'h100 + 32'(bk) * 32'd4;
            tests++; if (wdata !== exp_d || wlast !== (4'(bk) == lens[bi]) || wid !== 4'(bi)) begin fails++; $display("FAIL stall_wbeat b=%0d k=%0d got=%0h/%0b/%0d exp=%0h/%0b/%0d", bi, bk, wdata, wlast, wid, exp_d, 4'(bk) == lens[bi], bi); end
            total++;
            if (4'(bk) == lens[bi]) begin bi++; bk = 0; bursts_done++; end else bk++;
          end
          aw_hold = awvalid && !awready; p_awaddr = awaddr; p_awlen = awlen;
          w_hold  = wvalid && !wready;   p_wdata = wdata; p_wlast = wlast; p_wid = wid;
        end
        tests++; if (total != 60) begin fails++; $display("FAIL stall_total_beats got=%0d exp=60", total); end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          int guard;
          guard = 0;
          while (bursts_done <= i && guard < 4000) begin @(negedge aclk); guard++; end
          send_b(4'(i), 2'b00);
        end
      end
    join
    awready = 1'b1; wready = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    tests++; if (wr_ostd_cnt !== 3'd0 || err_cnt !== 8'd0 || idle !== 1'b1) begin fails++; $display("FAIL stall_done ostd=%0d err=%0d idle=%0b exp=0/0/1", wr_ostd_cnt, err_cnt, idle); end
  endtask

  task automatic test_bresp_err();
    apply_reset();
    awready = 1'b1; wready = 1'b1;
    send_cmd(1'b1, 32'h40, 4'd0, 4'd2);
    repeat (6) @(negedge aclk);
    send_b(4'd7, 2'b10);
    #1;
    tests++; if (err_cnt !== 8'd1 || wr_ostd_cnt !== 3'd0) begin fails++; $display("FAIL bresp_err err=%0d ostd=%0d exp=1/0", err_cnt, wr_ostd_cnt); end
    @(negedge aclk);
    send_b(4'd3, 2'b00);
    #1;
    tests++; if (err_cnt !== 8'd2 || wr_ostd_cnt !== 3'd0) begin fails++; $display("FAIL spurious_b err=%0d ostd=%0d exp=2/0", err_cnt, wr_ostd_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    logic found;
    int beats;
    apply_reset();
    awready = 1'b1; wready = 1'b1;
    send_cmd(1'b1, 32'h300, 4'd7, 4'd1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (wvalid === 1'b1 && wdata === 32'h308) begin found = 1'b1; break; end
      @(negedge aclk);
    end
    tests++; if (!found) begin fails++; $display("FAIL midrst_reach_beat2 got=%0h exp=308", wdata); end
    areset = 1'b1;
    #1;
    tests++; if (wvalid !== 1'b0 || wdata !== 32'd0 || wlast !== 1'b0) begin fails++; $display("FAIL midrst_w got=%0b/%0h/%0b exp=0/0/0", wvalid, wdata, wlast); end
    tests++; if (wr_ostd_cnt !== 3'd0 || idle !== 1'b1 || err_cnt !== 8'd0) begin fails++; $display("FAIL midrst_state ostd=%0d idle=%0b err=%0d exp=0/1/0", wr_ostd_cnt, idle, err_cnt); end
    @(negedge aclk);
    areset = 1'b0;
    awready = 1'b1; wready = 1'b1;
    @(negedge aclk);
    send_cmd(1'b1, 32'h500, 4'd1, 4'd4);
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      #1;
      if (wvalid === 1'b1) begin
        tests++; if (wdata !== 32'h500 + 32'(beats) * 32'd4 || wlast !== (beats == 1) || wid !== 4'd4) begin fails++; $display("FAIL midrst_fresh beat=%0d got=%0h/%0b/%0d exp=%0h/%0b/4", beats, wdata, wlast, wid, 32'h500 + 32'(beats) * 32'd4, beats == 1); end
        beats++;
      end
      @(negedge aclk);
    end
    tests++; if (beats != 2) begin fails++; $display("FAIL midrst_fresh_count got=%0d exp=2", beats); end
    send_b(4'd4, 2'b00);
    #1;
    tests++; if (wr_ostd_cnt !== 3'd0 || err_cnt !== 8'd0 || idle !== 1'b1) begin fails++; $display("FAIL midrst_done ostd=%0d err=%0d idle=%0b exp=0/0/1", wr_ostd_cnt, err_cnt, idle); end
  endtask

  initial begin
    areset = 1'b1;
    clear_inputs();
    test_reset();
    test_write_basic();
    test_read_ostd();
    test_rlast_early();
    test_random_stall();
    test_bresp_err();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
